// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. One full-adder cell is reused across
// WIDTH clock cycles, LSB first. Operands live in right-shifting registers, the
// running carry in a single flop, and sum bits enter the result register from
// the MSB side so that bit 0 reaches sum[0] after the last shift.
//
// Handshake: start is sampled only while busy=0, that is in IDLE and in the
// single DONE cycle, so starts can run back to back with no bubble. busy is
// high for the WIDTH cycles after the accepting edge. done pulses for one
// cycle with sum/carry valid, and both results hold until the next accepted
// start clears them.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             cf;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             fa_s;
  logic             fa_c;

  // A start is accepted whenever no addition is in flight (IDLE or DONE).
  assign accept = start && (state_q != ADD);
  assign last   = (cnt == CW'(WIDTH - 1));

  // The shared full-adder cell.
  assign fa_s = a_sr[0] ^ b_sr[0] ^ cf;
  assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & cf) | (b_sr[0] & cf);

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs decoded from the registered state.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    state_dbg = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? ADD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, otherwise shift one bit per ADD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      cf    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      cf    <= cin;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (state_q == ADD) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      cf   <= fa_c;
      sum  <= {fa_s, sum[WIDTH-1:1]};
      // The counter stops at WIDTH-1 because the FSM leaves ADD there.
      if (last) carry <= fa_c;
      else      cnt   <= cnt + 1'b1;
    end
  end

endmodule
